spi_mem_arbiter: RTL and testbench

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

---
 rtl/spi_mem_arbiter_if.sv | 37 +++
 rtl/spi_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_arbiter_if.sv
// Purpose: bundles the two requester ports and the memory port of spi_mem_arbiter.
// Latency: n/a (wires only).
// Backpressure: none here; the arbiter holds requests off while busy.
// Ports (slave = arbiter side):
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1, lock0 : requester inputs
//   gnt0/gnt1, rvalid0/rvalid1, rdata, busy                : requester outputs
//   mem_en, mem_we, mem_addr, mem_wdata / mem_rdata         : memory out / in
interface spi_mem_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 8
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          lock0;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Purpose: two-port (SPI slave / local core) arbiter onto a single-port synchronous memory.
// Latency: gnt in the cycle after the req-sampling edge, rvalid one cycle later; write every 2, read every 3 cycles.
// Backpressure: requests seen outside IDLE are ignored until the next IDLE; port 0 lock starves port 1 for at most LOCK_MAX grants.
// Ports: clk, rst_n (async active-low); bus = spi_mem_arbiter_if.slave carrying both requester ports and the memory port.
module spi_mem_arbiter #(
  parameter int AW       = 7,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_LIM = 4'(LOCK_MAX - 1);

  state_t        state_q;
  logic          owner_q;
  logic          we_q;
  logic          last_owner_q;
  logic          lock_q;
  logic [3:0]    lock_cnt_q;
  logic          gnt0_q, gnt1_q;
  logic          rvalid0_q, rvalid1_q;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          busy_q;

  logic          lock_act;
  logic          win_vld_d;
  logic          win_d;
  logic [3:0]    lock_cnt_d;

  // IDLE arbitration. The lock only counts while lock0 is still held, so a
  // lock being released in this IDLE cycle already arbitrates round-robin.
  always_comb begin
    lock_act   = lock_q & bus.lock0;
    win_vld_d  = 1'b0;
    win_d      = 1'b0;
    lock_cnt_d = lock_act ? lock_cnt_q : 4'd0;
    if (lock_act) begin
      if (bus.req1 && lock_cnt_q == CNT_LIM) begin
        // starvation limit reached: port 1 gets one forced grant
        win_vld_d  = 1'b1;
        win_d      = 1'b1;
        lock_cnt_d = 4'd0;
      end else if (bus.req0) begin
        win_vld_d = 1'b1;
        win_d     = 1'b0;
        if (bus.req1 && lock_cnt_q != 4'hF)
          lock_cnt_d = lock_cnt_q + 4'd1;
      end
    end else if (bus.req0 && bus.req1) begin
      win_vld_d = 1'b1;
      win_d     = ~last_owner_q;
    end else if (bus.req0 || bus.req1) begin
      win_vld_d = 1'b1;
      win_d     = bus.req1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      last_owner_q <= 1'b1;   // port 0 wins the first tie
      lock_q       <= 1'b0;
      lock_cnt_q   <= 4'd0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      // every pulse output lasts exactly one cycle
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      case (state_q)
        IDLE: begin
          lock_cnt_q <= lock_cnt_d;
          if (!bus.lock0)
            lock_q <= 1'b0;
          if (win_vld_d) begin
            state_q     <= ACCESS;
            busy_q      <= 1'b1;
            owner_q     <= win_d;
            we_q        <= win_d ? bus.we1 : bus.we0;
            gnt0_q      <= ~win_d;
            gnt1_q      <= win_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= win_d ? bus.we1 : bus.we0;
            mem_addr_q  <= win_d ? bus.addr1 : bus.addr0;
            mem_wdata_q <= win_d ? bus.wdata1 : bus.wdata0;
          end
        end
        ACCESS: begin
          last_owner_q <= owner_q;
          if (!owner_q && bus.lock0)
            lock_q <= 1'b1;
          if (we_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= RESP;
            rvalid0_q <= ~owner_q;
            rvalid1_q <= owner_q;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  // memory data arrives during RESP, which is exactly when rvalid is high
  assign bus.rdata     = (rvalid0_q | rvalid1_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
module tb_spi_mem_arbiter;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int LOCK_MAX = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  spi_mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // synchronous memory with a backdoor load port for preloading
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_dat = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  typedef struct packed {
    logic rst_n, req0, req1, we0, we1, lock0;
    logic [6:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
  } vin_t;

  typedef struct packed {
    logic gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy;
    logic [6:0] mem_addr;
    logic [7:0] rdata;
  } vout_t;

  typedef struct {
    vin_t  i;
    vout_t o;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vin_t mi(input logic rs, r0, r1, w0, w1, lk,
                              input logic [6:0] a0, a1, input logic [7:0] d0, d1);
    vin_t v;
    v.rst_n = rs; v.req0 = r0; v.req1 = r1; v.we0 = w0; v.we1 = w1; v.lock0 = lk;
    v.addr0 = a0; v.addr1 = a1; v.wdata0 = d0; v.wdata1 = d1;
    return v;
  endfunction

  function automatic vout_t mo(input logic g0, g1, v0, v1, en, we, bz,
                               input logic [6:0] ad, input logic [7:0] rd);
    vout_t v;
    v.gnt0 = g0; v.gnt1 = g1; v.rvalid0 = v0; v.rvalid1 = v1;
    v.mem_en = en; v.mem_we = we; v.busy = bz; v.mem_addr = ad; v.rdata = rd;
    return v;
  endfunction

  task automatic add(input vin_t i, input vout_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(input vin_t v);
    rst_n = v.rst_n;
    bus.req0 = v.req0; bus.req1 = v.req1;
    bus.we0 = v.we0; bus.we1 = v.we1; bus.lock0 = v.lock0;
    bus.addr0 = v.addr0; bus.addr1 = v.addr1;
    bus.wdata0 = v.wdata0; bus.wdata1 = v.wdata1;
  endtask

  function automatic vout_t sample();
    vout_t s;
    s.gnt0 = bus.gnt0; s.gnt1 = bus.gnt1;
    s.rvalid0 = bus.rvalid0; s.rvalid1 = bus.rvalid1;
    s.mem_en = bus.mem_en; s.mem_we = bus.mem_we; s.busy = bus.busy;
    s.mem_addr = bus.mem_addr; s.rdata = bus.rdata;
    return s;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_addr = a; pl_dat = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input string nm, output logic who, output logic ok);
    int c;
    ok = 1'b0;
    who = 1'b0;
    c = 0;
    while (!ok && c < 8) begin
      @(posedge clk); #1;
      if (bus.gnt0 || bus.gnt1) begin
        ok = 1'b1;
        who = bus.gnt1;
      end
      c++;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no grant within 8 cycles", nm);
    end
  endtask

  // structural invariants, every cycle
  always @(negedge clk) begin
    n_cmp++;
    if ((bus.gnt0 & bus.gnt1) | (bus.rvalid0 & bus.rvalid1) |
        (bus.mem_we & ~bus.mem_en) | (bus.mem_en & ~bus.busy)) begin
      n_bad++;
      $display("FAIL excl: gnt=%b%b rvalid=%b%b mem_en=%b mem_we=%b busy=%b",
               bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_en, bus.mem_we, bus.busy);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vout_t z;
    vin_t  idle;
    logic  who, ok;

    z    = mo(0, 0, 0, 0, 0, 0, 0, 7'h00, 8'h00);
    idle = mi(1, 0, 0, 0, 0, 0, 7'h00, 7'h00, 8'h00, 8'h00);

    drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 rst_n = 1'b0;
    preload(7'h05, 8'hA5);
    preload(7'h30, 8'h3C);
    preload(7'h31, 8'hC3);

    // reset state, then idle for 10 cycles
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);
    for (int k = 0; k < 10; k++) add(idle, z);
    // single read from port 1
    add(mi(1, 0, 1, 0, 0, 0, 7'h00, 7'h05, 8'h00, 8'h00), mo(0, 1, 0, 0, 1, 0, 1, 7'h05, 8'h00));
    add(idle, mo(0, 0, 0, 1, 0, 0, 1, 7'h00, 8'hA5));
    add(idle, z);
    // reset, then simultaneous writes: port 0 first, port 1 two cycles later
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);
    add(mi(1, 1, 1, 1, 1, 0, 7'h10, 7'h20, 8'h11, 8'h22), mo(1, 0, 0, 0, 1, 1, 1, 7'h10, 8'h00));
    add(mi(1, 0, 1, 1, 1, 0, 7'h10, 7'h20, 8'h11, 8'h22), z);
    add(mi(1, 0, 1, 0, 1, 0, 7'h00, 7'h20, 8'h00, 8'h22), mo(0, 1, 0, 0, 1, 1, 1, 7'h20, 8'h00));
    add(idle, z);
    // read back both; req1 arriving during RESP is held off to the next IDLE
    add(mi(1, 1, 0, 0, 0, 0, 7'h10, 7'h00, 8'h00, 8'h00), mo(1, 0, 0, 0, 1, 0, 1, 7'h10, 8'h00));
    add(idle, mo(0, 0, 1, 0, 0, 0, 1, 7'h00, 8'h11));
    add(mi(1, 0, 1, 0, 0, 0, 7'h00, 7'h20, 8'h00, 8'h00), z);
    add(mi(1, 0, 1, 0, 0, 0, 7'h00, 7'h20, 8'h00, 8'h00), mo(0, 1, 0, 0, 1, 0, 1, 7'h20, 8'h00));
    add(idle, mo(0, 0, 0, 1, 0, 0, 1, 7'h00, 8'h22));
    add(idle, z);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive(tbl[k].i);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", k), 32'(sample()), 32'(tbl[k].o));
    end
    chk("mem10", 32'(mem[7'h10]), 32'h11);
    chk("mem20", 32'(mem[7'h20]), 32'h22);

    // round-robin with both ports reading continuously
    do_reset();
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 7'h30; bus.addr1 = 7'h31;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_gnt("rr_wait", who, ok);
      if (ok) begin
        chk($sformatf("rr_owner%0d", k), 32'(who), 32'(k % 2));
        @(posedge clk); #1;
        chk($sformatf("rr_rvalid%0d", k), 32'({bus.rvalid1, bus.rvalid0}), who ? 32'd2 : 32'd1);
        chk($sformatf("rr_rdata%0d", k), 32'(bus.rdata), who ? 32'hC3 : 32'h3C);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // lock starvation: 16 port-0 grants, one forced port-1 grant, repeat
    do_reset();
    bus.lock0 = 1'b1;
    bus.we0 = 1'b1; bus.we1 = 1'b1;
    bus.addr0 = 7'h40; bus.addr1 = 7'h41;
    bus.wdata0 = 8'h44; bus.wdata1 = 8'h55;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int g = 0; g < 33; g++) begin
      wait_gnt("lock_wait", who, ok);
      if (ok) chk($sformatf("lock_g%0d", g), 32'(who), (g == 16 || g == 32) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0;
    @(negedge clk);
    chk("mem40", 32'(mem[7'h40]), 32'h44);
    chk("mem41", 32'(mem[7'h41]), 32'h55);

    // reset during ACCESS of a read: outputs drop at once, no rvalid
    do_reset();
    bus.we0 = 1'b0; bus.addr0 = 7'h05; bus.req0 = 1'b1;
    @(posedge clk); #1;
    chk("rmr_gnt", 32'(bus.gnt0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmr_async", 32'(sample()), 32'(z));
    @(posedge clk); #1;
    chk("rmr_norv", 32'(sample()), 32'(z));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rmr_regnt", 32'(sample()), 32'(mo(1, 0, 0, 0, 1, 0, 1, 7'h05, 8'h00)));
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    chk("rmr_rdata", 32'(sample()), 32'(mo(0, 0, 1, 0, 0, 0, 1, 7'h00, 8'hA5)));
    @(posedge clk); #1;
    chk("rmr_idle", 32'(sample()), 32'(z));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
